// File: rtl/rvc_pkg.sv
// Shared definitions for the RV32C fetch aligner.
//   HW_W          - halfword width
//   RV32_LEN_MARK - low two bits that mark a 32-bit instruction
//   BUF_HW        - halfword buffer depth
//   is_compressed - true when a halfword starts a 16-bit instruction
package rvc_pkg;

  localparam int unsigned HW_W          = 16;
  localparam logic [1:0]  RV32_LEN_MARK = 2'b11;
  localparam int unsigned BUF_HW        = 3;

  function automatic logic is_compressed(logic [HW_W-1:0] hw);
    return hw[1:0] != RV32_LEN_MARK;
  endfunction

endpackage

// File: rtl/rvc_len_decode.sv
// Instruction length decode for the two oldest buffered halfwords.
//   count_i - number of valid halfwords in the buffer (0..3)
//   hb0_i   - oldest halfword
//   hb1_i   - next halfword
//   valid_o - a complete instruction is available
//   is_c_o  - that instruction is compressed
//   ir_o    - instruction, compressed ones zero-extended; zero when not valid
//   used_o  - halfwords the instruction occupies (0 when not valid)
module rvc_len_decode
  import rvc_pkg::*;
(
  input  logic [1:0]        count_i,
  input  logic [HW_W-1:0]   hb0_i,
  input  logic [HW_W-1:0]   hb1_i,
  output logic              valid_o,
  output logic              is_c_o,
  output logic [2*HW_W-1:0] ir_o,
  output logic [1:0]        used_o
);

  always_comb begin
    valid_o = 1'b0;
    is_c_o  = 1'b0;
    ir_o    = '0;
    used_o  = 2'd0;
    if (count_i >= 2'd1 && is_compressed(hb0_i)) begin
      valid_o = 1'b1;
      is_c_o  = 1'b1;
      ir_o    = {{HW_W{1'b0}}, hb0_i};
      used_o  = 2'd1;
    end else if (count_i >= 2'd2 && !is_compressed(hb0_i)) begin
      valid_o = 1'b1;
      ir_o    = {hb1_i, hb0_i};
      used_o  = 2'd2;
    end
    // count_i == 1 with a 32-bit marker: wait for the upper half.
  end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Halfword aligner between the fetch unit and the RV32I/RV32C decoders.
// Buffers sequential 32-bit fetch words as halfwords and presents one
// instruction (16- or 32-bit) per cycle with its PC. Handles 32-bit
// instructions straddling fetch words and halfword-aligned redirects.
//   iCLK, iRST_N   - clock, async active-low reset
//   iFETCH_DATA    - fetch word, [15:0] at the lower address
//   iFETCH_VALID   - fetch word valid
//   oFETCH_READY   - a fetch word can be taken this cycle
//   iFLUSH         - redirect; iFLUSH_PC is the halfword-aligned target
//   oIR/oIS_C/oPC  - instruction, compressed flag, address
//   oVALID/iREADY  - downstream handshake
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic [31:0]     iFETCH_DATA,
  input  logic            iFETCH_VALID,
  output logic            oFETCH_READY,
  input  logic            iFLUSH,
  input  logic [PC_W-1:0] iFLUSH_PC,
  output logic [31:0]     oIR,
  output logic            oIS_C,
  output logic [PC_W-1:0] oPC,
  output logic            oVALID,
  input  logic            iREADY
);

  logic [HW_W-1:0] hb_q [BUF_HW];
  logic [HW_W-1:0] hb_d [BUF_HW];
  logic [1:0]      count_q, count_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            skip_q, skip_d;

  logic            dec_valid;
  logic            dec_is_c;
  logic [31:0]     dec_ir;
  logic [1:0]      dec_used;

  logic            fetch_ready;
  logic            accept;
  logic            consume;
  logic [1:0]      remain;

  rvc_len_decode u_len_decode (
    .count_i (count_q),
    .hb0_i   (hb_q[0]),
    .hb1_i   (hb_q[1]),
    .valid_o (dec_valid),
    .is_c_o  (dec_is_c),
    .ir_o    (dec_ir),
    .used_o  (dec_used)
  );

  // Ready depends only on registered count, so there is no path from iREADY.
  assign fetch_ready = (count_q <= 2'd1);
  assign accept      = iFETCH_VALID && fetch_ready && !iFLUSH;
  assign consume     = dec_valid && iREADY && !iFLUSH;

  always_comb begin
    hb_d    = hb_q;
    count_d = count_q;
    pc_d    = pc_q;
    skip_d  = skip_q;
    remain  = count_q;
    if (iFLUSH) begin
      count_d = 2'd0;
      pc_d    = iFLUSH_PC;
      // A target in the upper half of a word means its low half is dropped.
      skip_d  = iFLUSH_PC[1];
    end else begin
      if (consume) begin
        remain = count_q - dec_used;
        pc_d   = pc_q + PC_W'({dec_used, 1'b0});
        unique case (dec_used)
          2'd1: begin
            hb_d[0] = hb_q[1];
            hb_d[1] = hb_q[2];
          end
          2'd2: hb_d[0] = hb_q[2];
          default: ;
        endcase
      end
      count_d = remain;
      // Accept implies count_q <= 1, so remain <= 1 and both halves fit.
      if (accept) begin
        if (skip_q) begin
          for (int i = 0; i < BUF_HW; i++) begin
            if (i == int'(remain)) hb_d[i] = iFETCH_DATA[31:16];
          end
          count_d = remain + 2'd1;
          skip_d  = 1'b0;
        end else begin
          for (int i = 0; i < BUF_HW; i++) begin
            if (i == int'(remain))     hb_d[i] = iFETCH_DATA[15:0];
            if (i == int'(remain) + 1) hb_d[i] = iFETCH_DATA[31:16];
          end
          count_d = remain + 2'd2;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < BUF_HW; i++) hb_q[i] <= '0;
      count_q <= 2'd0;
      pc_q    <= RESET_PC;
      skip_q  <= RESET_PC[1];
    end else begin
      hb_q    <= hb_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

  assign oFETCH_READY = fetch_ready;
  assign oVALID       = dec_valid;
  assign oIS_C        = dec_is_c;
  assign oIR          = dec_ir;
  assign oPC          = pc_q;

endmodule
